// File: rtl/ex_mem_pipe_pkg.sv
// Shared widths, halt FSM encodings and the EX/MEM control bundle layout.
// No logic; pure type/parameter definitions.
// Imported by every file of the EX/MEM pipeline register.
package ex_mem_pipe_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } halt_st_e;

    // Control bundle, MSB first: valid, pcsrc, mem_read, mem_write, reg_write
    typedef struct packed {
        logic valid;
        logic pcsrc;
        logic mem_read;
        logic mem_write;
        logic reg_write;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ex_mem_pipe_reg.sv
// Generic pipeline flop: async active-low reset, load enable, synchronous clear.
// Latency: one cycle d->q when en=1.
// Holds its value when en=0; clr (only honoured while enabled) loads zero.
module pipe_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Next value: hold unless enabled, clear takes precedence over load
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = clr ? '0 : d;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with load-use warnings and halt retirement tracking.
// Latency: one cycle EX->MEM; load warnings are combinational on EX inputs.
// mem_stall freezes everything; flush captures a bubble; after HALT only bubbles enter.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W  = ex_mem_pipe_pkg::DATA_W,
    parameter int RADDR_W = ex_mem_pipe_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu_out,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic [DATA_W-1:0]  ex_pc_next,
    input  logic [DATA_W-1:0]  ex_pc_inc,
    input  logic               ex_pcsrc,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_reg_write,
    input  logic [RADDR_W-1:0] ex_wreg,
    input  logic               ex_halt,
    input  logic [RADDR_W-1:0] ex_rs,
    input  logic [RADDR_W-1:0] ex_rt,
    input  logic               ex_uses_rs,
    input  logic               ex_uses_rt,
    input  logic               mem_stall,
    input  logic               flush,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_alu_out,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [DATA_W-1:0]  mem_pc_next,
    output logic [DATA_W-1:0]  mem_pc_inc,
    output logic               mem_mem_read,
    output logic               mem_mem_write,
    output logic               mem_reg_write,
    output logic [RADDR_W-1:0] mem_wreg,
    output logic               redirect,
    output logic               load_warning_a,
    output logic               load_warning_b,
    output logic               halted
);

    halt_st_e state_d, state_q;
    logic     halted_d, halted_q;
    logic     run;
    logic     data_en;
    ctrl_t    ctrl_d, ctrl_q;

    assign run = (state_q == ST_RUN);

    // Data fields are don't-care in a bubble, so a flush simply leaves them alone
    assign data_en = !mem_stall && !flush;

    // Control bundle: once HALT is committed ex_valid is ignored so nothing else retires
    always_comb begin
        ctrl_d           = '0;
        ctrl_d.valid     = ex_valid && run;
        ctrl_d.pcsrc     = ctrl_d.valid && ex_pcsrc;
        ctrl_d.mem_read  = ctrl_d.valid && ex_mem_read;
        ctrl_d.mem_write = ctrl_d.valid && ex_mem_write;
        ctrl_d.reg_write = ctrl_d.valid && ex_reg_write;
    end

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .en(!mem_stall), .clr(flush), .d(ctrl_d), .q(ctrl_q)
    );
    pipe_reg #(.W(DATA_W)) u_alu (
        .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0), .d(ex_alu_out), .q(mem_alu_out)
    );
    pipe_reg #(.W(DATA_W)) u_wdata (
        .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0), .d(ex_wdata), .q(mem_wdata)
    );
    pipe_reg #(.W(DATA_W)) u_pc_next (
        .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0), .d(ex_pc_next), .q(mem_pc_next)
    );
    pipe_reg #(.W(DATA_W)) u_pc_inc (
        .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0), .d(ex_pc_inc), .q(mem_pc_inc)
    );
    pipe_reg #(.W(RADDR_W)) u_wreg (
        .clk(clk), .rst_n(rst_n), .en(data_en), .clr(1'b0), .d(ex_wreg), .q(mem_wreg)
    );

    assign mem_valid     = ctrl_q.valid;
    assign mem_mem_read  = ctrl_q.mem_read;
    assign mem_mem_write = ctrl_q.mem_write;
    assign mem_reg_write = ctrl_q.reg_write;

    // pcsrc is only latched with a valid instruction, and a stall holds it, so it stays up until release
    assign redirect = ctrl_q.valid && ctrl_q.pcsrc;

    // Load-use hazard: MEM holds a load whose destination is a source the EX instruction reads
    always_comb begin
        load_warning_a = ctrl_q.valid && ctrl_q.mem_read && ctrl_q.reg_write && ex_valid
                         && ex_uses_rs && (mem_wreg == ex_rs);
        load_warning_b = ctrl_q.valid && ctrl_q.mem_read && ctrl_q.reg_write && ex_valid
                         && ex_uses_rt && (mem_wreg == ex_rt);
    end

    // Halt FSM next state: a flushed HALT never commits; once in DRAIN a flush cannot undo it
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (!mem_stall) begin
            case (state_q)
                ST_RUN: begin
                    if (ex_valid && ex_halt && !flush) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Halt FSM state and its registered halted output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;

endmodule
